alu_op_sequencer: RTL and testbench



---
 rtl/alu_op_sequencer.sv | 162 ++++++++++++++++
 tb/tb_alu_op_sequencer.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: drives operands into an ALU, waits ALU_LAT cycles,
// samples the result and returns it in command order through a response FIFO.
// Optional statistics counters are enabled with the macro ALU_SEQ_STATS_EN.
module alu_op_sequencer #(
  parameter int DATA_W    = 8,
  parameter int OP_W      = 4,
  parameter int ALU_LAT   = 1,
  parameter int RSP_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [DATA_W-1:0] cmd_a,
  input  logic [DATA_W-1:0] cmd_b,
  input  logic [OP_W-1:0]   cmd_op,
  output logic [DATA_W-1:0] a_out,
  output logic [DATA_W-1:0] b_out,
  output logic [OP_W-1:0]   op_out,
  input  logic [DATA_W-1:0] y_in,
  input  logic              co_in,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_y,
  output logic              rsp_co,
`ifdef ALU_SEQ_STATS_EN
  output logic [15:0]       stat_ops,
  output logic [15:0]       stat_carry,
`endif
  output logic              busy
);

  localparam int PTR_W = $clog2(RSP_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [3:0] LAT_LOAD = 4'(ALU_LAT - 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RSP_DEPTH);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                load;
  logic                push;
  logic                pop;
  logic                ready_q, ready_d;
  logic [DATA_W-1:0]   a_q, b_q;
  logic [OP_W-1:0]     op_q;
  logic [DATA_W:0]     mem_q [RSP_DEPTH];
  logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]    count_q, count_d;

  assign rsp_valid = (count_q != '0);
  assign pop       = rsp_valid && rsp_ready;
  assign cmd_ready = ready_q;
  assign busy      = (state_q != S_IDLE);
  assign a_out     = a_q;
  assign b_out     = b_q;
  assign op_out    = op_q;
  assign rsp_y     = mem_q[rd_ptr_q][DATA_W:1];
  assign rsp_co    = mem_q[rd_ptr_q][0];

  // Next-state, wait counter and FIFO occupancy logic.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    load    = 1'b0;
    push    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (cmd_valid && ready_q) begin
          load    = 1'b1;
          cnt_d   = LAT_LOAD;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_CAPTURE;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_CAPTURE: begin
        push    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    // Ready is a register, so a pop only frees a slot for the next cycle.
    ready_d = (state_d == S_IDLE) && (count_d < DEPTH_C);
  end

  // FSM state, wait counter and registered command ready.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ready_q <= ready_d;
    end
  end

  // Operand registers hold their value until the next accepted command.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= '0;
    end else if (load) begin
      a_q  <= cmd_a;
      b_q  <= cmd_b;
      op_q <= cmd_op;
    end
  end

  // Response FIFO storage, pointers and occupancy.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RSP_DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= {y_in, co_in};
        wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_d;
    end
  end

`ifdef ALU_SEQ_STATS_EN
  logic [15:0] stat_ops_q, stat_carry_q;

  assign stat_ops   = stat_ops_q;
  assign stat_carry = stat_carry_q;

  // Operation and carry counters, advanced on every capture; wrap naturally.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stat_ops_q   <= 16'd0;
      stat_carry_q <= 16'd0;
    end else if (state_q == S_CAPTURE) begin
      stat_ops_q <= stat_ops_q + 16'd1;
      if (co_in) stat_carry_q <= stat_carry_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer: one instance with ALU_LAT=1 and one with
// ALU_LAT=3, each wired to a small ALU model, with a response scoreboard.
module tb_alu_op_sequencer;

  logic clk;
  logic reset;
  int   checks = 0;
  int   fails  = 0;
  int   cyc    = 0;

  // DUT 1 (ALU_LAT = 1)
  logic       v1, cr1, rv1, rr1, rc1, co1, busy1;
  logic [7:0] a1, b1, ao1, bo1, y1, ry1;
  logic [3:0] op1, opo1;
  // DUT 2 (ALU_LAT = 3)
  logic       v2, cr2, rv2, rr2, rc2, co2, busy2;
  logic [7:0] a2, b2, ao2, bo2, y2, ry2;
  logic [3:0] op2, opo2;
`ifdef ALU_SEQ_STATS_EN
  logic [15:0] sops1, scar1, sops2, scar2;
`endif

  logic [8:0] q1[$];
  logic [8:0] q2[$];
  logic [8:0] e1, e2;
  int         npop1 = 0;

  alu_op_sequencer #(.DATA_W(8), .OP_W(4), .ALU_LAT(1), .RSP_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .cmd_valid(v1), .cmd_ready(cr1),
    .cmd_a(a1), .cmd_b(b1), .cmd_op(op1),
    .a_out(ao1), .b_out(bo1), .op_out(opo1), .y_in(y1), .co_in(co1),
    .rsp_valid(rv1), .rsp_ready(rr1), .rsp_y(ry1), .rsp_co(rc1),
`ifdef ALU_SEQ_STATS_EN
    .stat_ops(sops1), .stat_carry(scar1),
`endif
    .busy(busy1)
  );

  alu_op_sequencer #(.DATA_W(8), .OP_W(4), .ALU_LAT(3), .RSP_DEPTH(4)) dut2 (
    .clk(clk), .reset(reset), .cmd_valid(v2), .cmd_ready(cr2),
    .cmd_a(a2), .cmd_b(b2), .cmd_op(op2),
    .a_out(ao2), .b_out(bo2), .op_out(opo2), .y_in(y2), .co_in(co2),
    .rsp_valid(rv2), .rsp_ready(rr2), .rsp_y(ry2), .rsp_co(rc2),
`ifdef ALU_SEQ_STATS_EN
    .stat_ops(sops2), .stat_carry(scar2),
`endif
    .busy(busy2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(negedge clk) cyc <= cyc + 1;

  // ALU model 1: combinational; op 1 subtracts, anything else adds.
  assign {co1, y1} = (opo1 == 4'h1) ? ({1'b0, ao1} - {1'b0, bo1})
                                    : ({1'b0, ao1} + {1'b0, bo1});

  // ALU model 2: shows a junk value until its inputs have been stable long enough.
  logic [19:0] prev2;
  int          st2;
  logic        settled2;
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      prev2 <= '0;
      st2   <= 0;
    end else begin
      prev2 <= {ao2, bo2, opo2};
      if ({ao2, bo2, opo2} != prev2) st2 <= 0;
      else if (st2 < 100)            st2 <= st2 + 1;
    end
  end
  assign settled2  = ({ao2, bo2, opo2} == prev2) && (st2 >= 2);
  assign {co2, y2} = settled2 ? ({1'b0, ao2} + {1'b0, bo2}) : 9'h0EE;

  function automatic logic [8:0] exp_of(input logic [7:0] a, input logic [7:0] b,
                                        input logic [3:0] op);
    logic [8:0] s;
    s = (op == 4'h1) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    return {s[7:0], s[8]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response scoreboards: compare each popped head with the oldest expectation.
  always @(negedge clk) begin
    if (reset && rv1 && rr1) begin
      npop1++;
      if (q1.size() == 0) chk("rsp1_unexpected", 1, 0);
      else begin
        e1 = q1.pop_front();
        chk("rsp1_data", {ry1, rc1}, e1);
      end
    end
  end

  always @(negedge clk) begin
    if (reset && rv2 && rr2) begin
      if (q2.size() == 0) chk("rsp2_unexpected", 1, 0);
      else begin
        e2 = q2.pop_front();
        chk("rsp2_data", {ry2, rc2}, e2);
      end
    end
  end

  task automatic issue1(input logic [7:0] a, input logic [7:0] b, input logic [3:0] op);
    int n;
    n = 0;
    @(posedge clk); #1;
    v1 = 1'b1; a1 = a; b1 = b; op1 = op;
    @(negedge clk);
    while (!cr1 && n < 40) begin @(negedge clk); n++; end
    chk("issue1_accept", cr1, 1);
    @(posedge clk);
    q1.push_back(exp_of(a, b, op));
    #1 v1 = 1'b0;
  endtask

  task automatic wait_idle1();
    int n;
    n = 0;
    @(negedge clk);
    while (busy1 && n < 50) begin @(negedge clk); n++; end
    chk("idle1_bound", busy1, 0);
  endtask

  task automatic drain1();
    int n;
    n = 0;
    @(posedge clk); #1 rr1 = 1'b1;
    while (q1.size() != 0 && n < 60) begin @(negedge clk); n++; end
    chk("drain1_empty", q1.size(), 0);
    @(negedge clk);
    chk("drain1_rsp_valid", rv1, 0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int hi, t0, t1, n, base;
    reset = 1'b0;
    v1 = 0; a1 = 0; b1 = 0; op1 = 0; rr1 = 1'b1;
    v2 = 0; a2 = 0; b2 = 0; op2 = 0; rr2 = 1'b1;

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst_cmd_ready", cr1, 0);
    chk("rst_rsp_valid", rv1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_a_out", ao1, 0);
    chk("rst_op_out", opo1, 0);
    chk("rst_rsp", {ry1, rc1}, 0);
    reset = 1'b1;
    @(negedge clk);
    chk("post_rst_ready1", cr1, 1);
    chk("post_rst_ready2", cr2, 1);

    // Single op with timing, ALU_LAT = 1
    issue1(8'h0F, 8'h01, 4'h0);
    @(negedge clk);
    chk("single_busy", busy1, 1);
    chk("single_a_out", ao1, 8'h0F);
    chk("single_b_out", bo1, 8'h01);
    chk("single_ready_wait", cr1, 0);
    chk("single_rv_e0", rv1, 0);
    @(negedge clk);
    chk("single_rv_e1", rv1, 0);
    chk("single_busy_cap", busy1, 1);
    @(negedge clk);
    chk("single_rv_e2", rv1, 1);
    chk("single_y", ry1, 8'h10);
    chk("single_idle", busy1, 0);
    chk("single_ready_back", cr1, 1);
    @(negedge clk);
    chk("single_a_hold", ao1, 8'h0F);

    // Carry path
    issue1(8'hFF, 8'h01, 4'h0);
    wait_idle1();
    @(negedge clk);
    chk("carry_q_empty", q1.size(), 0);
`ifdef ALU_SEQ_STATS_EN
    chk("stat_ops", sops1, 2);
    chk("stat_carry", scar1, 1);
`endif

    // Opcode passed through (subtract with borrow)
    issue1(8'h05, 8'h20, 4'h1);
    @(negedge clk);
    chk("sub_op_out", opo1, 4'h1);
    wait_idle1();

    // Backpressure to full
    @(posedge clk); #1 rr1 = 1'b0;
    issue1(8'h11, 8'h01, 4'h0);
    issue1(8'h22, 8'h02, 4'h0);
    issue1(8'h33, 8'h03, 4'h0);
    issue1(8'h44, 8'h04, 4'h0);
    wait_idle1();
    @(posedge clk); #1;
    v1 = 1'b1; a1 = 8'h55; b1 = 8'h05; op1 = 4'h0;
    hi = 0;
    repeat (6) begin @(negedge clk); if (cr1) hi++; end
    chk("full_ready_low", hi, 0);
    chk("full_busy", busy1, 0);
    chk("full_head", {ry1, rc1}, exp_of(8'h11, 8'h01, 4'h0));
    @(posedge clk); #1 rr1 = 1'b1;
    @(negedge clk);
    chk("pop_ready_same", cr1, 0);
    @(posedge clk); #1 rr1 = 1'b0;
    @(negedge clk);
    chk("pop_ready_next", cr1, 1);
    @(posedge clk);
    q1.push_back(exp_of(8'h55, 8'h05, 4'h0));
    #1 v1 = 1'b0;
    @(negedge clk);
    chk("fifth_accepted", busy1, 1);
    wait_idle1();
    drain1();

    // Simultaneous push and pop at count 2
    @(posedge clk); #1 rr1 = 1'b0;
    issue1(8'h61, 8'h01, 4'h0);
    issue1(8'h72, 8'h02, 4'h0);
    wait_idle1();
    issue1(8'h83, 8'h03, 4'h0);
    @(posedge clk); #1 rr1 = 1'b1;
    @(posedge clk); #1 rr1 = 1'b0;
    @(negedge clk);
    chk("pp_rv", rv1, 1);
    chk("pp_head", {ry1, rc1}, exp_of(8'h72, 8'h02, 4'h0));
    base = npop1;
    drain1();
    chk("pp_count", npop1 - base, 2);

    // Latency sweep on the ALU_LAT = 3 instance, back-to-back commands
    @(posedge clk); #1;
    v2 = 1'b1; a2 = 8'h21; b2 = 8'h13; op2 = 4'h0;
    n = 0;
    @(negedge clk);
    while (!cr2 && n < 40) begin @(negedge clk); n++; end
    chk("lat3_accept0", cr2, 1);
    @(posedge clk);
    t0 = cyc;
    q2.push_back(exp_of(8'h21, 8'h13, 4'h0));
    #1 a2 = 8'h3C; b2 = 8'hC8;
    n = 0;
    @(negedge clk);
    while (!cr2 && n < 40) begin @(negedge clk); n++; end
    chk("lat3_accept1", cr2, 1);
    @(posedge clk);
    t1 = cyc;
    q2.push_back(exp_of(8'h3C, 8'hC8, 4'h0));
    #1 v2 = 1'b0;
    chk("lat3_interval", t1 - t0, 5);
    n = 0;
    while (q2.size() != 0 && n < 40) begin @(negedge clk); n++; end
    chk("lat3_q_empty", q2.size(), 0);

    // Reset during WAIT with two responses queued
    @(posedge clk); #1 rr1 = 1'b0;
    issue1(8'h91, 8'h01, 4'h0);
    issue1(8'hA2, 8'h02, 4'h0);
    wait_idle1();
    issue1(8'hB3, 8'h03, 4'h0);
    reset = 1'b0;
    #1;
    chk("mid_rst_rv", rv1, 0);
    chk("mid_rst_busy", busy1, 0);
    chk("mid_rst_ready", cr1, 0);
    chk("mid_rst_a_out", ao1, 0);
    q1.delete();
    @(negedge clk);
    reset = 1'b1;
    rr1 = 1'b1;
    base = npop1;
    repeat (8) @(negedge clk);
    chk("post_rst_no_rsp", npop1 - base, 0);
    chk("post_rst_rv", rv1, 0);
    chk("post_rst_ready", cr1, 1);
    issue1(8'h30, 8'h40, 4'h0);
    wait_idle1();
    @(negedge clk);
    chk("post_rst_op_q", q1.size(), 0);
`ifdef ALU_SEQ_STATS_EN
    chk("post_rst_stat_ops", sops1, 1);
    chk("post_rst_stat_carry", scar1, 0);
`endif

    repeat (3) @(negedge clk);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
